store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/lc3b_types.sv | 23 ++
 rtl/store_buffer.sv | 168 ++++++++++++++++
 tb/tb_store_buffer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types -- shared LC-3b datapath types.
//
// Contents:
//   lc3b_word          16-bit machine word
//   lc3b_cache_offset  word index within a 16-byte cache line (address bits [3:1])
//   lc3b_sb_entry      one store-buffer entry: word address, byte enables, data
//   SB_DEPTH           default number of store-buffer entries
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_cache_offset;

    localparam int SB_DEPTH = 4;

    // waddr holds byte-address bits [15:1]; be[0] covers data[7:0] and be[1]
    // covers data[15:8].
    typedef struct packed {
        logic [14:0] waddr;
        logic [1:0]  be;
        lc3b_word    data;
    } lc3b_sb_entry;

endpackage

// File: rtl/store_buffer.sv
// store_buffer -- coalescing in-order store buffer between the CPU store port
// and the cache write path.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   st_valid / st_ready       CPU store handshake (st_ready = !full)
//   st_addr, st_data          store byte address and data
//   st_mem_byte_enable        byte enables (bit0 = low byte, bit1 = high byte)
//   drn_valid / drn_ready     head entry handshake towards the cache
//   drn_line_addr             head entry address bits [15:4]
//   drn_offset                head entry address bits [3:1] (cache sel)
//   drn_selbyte, drn_wdata    head entry byte enables and merged data
//   ld_addr, ld_hazard        load address and "pending store covers this word"
//   empty, full               occupancy status
//
// A store to the same word as the youngest entry merges into it, so the
// merged entry keeps its original drain position. Stores with no byte enabled
// are accepted and dropped.
module store_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  lc3b_word         st_addr,
    input  lc3b_word         st_data,
    input  logic [1:0]       st_mem_byte_enable,
    output logic             drn_valid,
    input  logic             drn_ready,
    output logic [11:0]      drn_line_addr,
    output lc3b_cache_offset drn_offset,
    output logic [1:0]       drn_selbyte,
    output lc3b_word         drn_wdata,
    input  lc3b_word         ld_addr,
    output logic             ld_hazard,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lc3b_sb_entry     entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_last;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rel;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic             coalesce;
    logic             alloc;
    lc3b_sb_entry     head_entry;
    lc3b_sb_entry     tail_entry;
    lc3b_sb_entry     wr_entry;

    // Address bit 0 only selects a byte inside the word; entries track words.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, st_addr[0], ld_addr[0]};

    // ------------------------------------------------------------------
    // Status and handshakes
    // ------------------------------------------------------------------
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign st_ready  = !full;
    assign drn_valid = !empty;

    assign push = st_valid && st_ready && (st_mem_byte_enable != 2'b00);
    assign pop  = drn_valid && drn_ready;

    // tail points at the next free slot; the youngest entry sits just behind it.
    assign tail_last  = tail - 1'b1;
    assign head_entry = entries[head];
    assign tail_entry = entries[tail_last];

    // With a single entry the tail is the head, so a pop in the same cycle
    // would carry the merged bytes away; allocate a fresh entry instead.
    assign coalesce = push && !empty
                      && (st_addr[15:1] == tail_entry.waddr)
                      && !(pop && count == CNT_W'(1));
    assign alloc    = push && !coalesce;
    assign wr_idx   = coalesce ? tail_last : tail;

    // Drain outputs come straight from the head register.
    assign drn_line_addr = head_entry.waddr[14:3];
    assign drn_offset    = head_entry.waddr[2:0];
    assign drn_selbyte   = head_entry.be;
    assign drn_wdata     = head_entry.data;

    // ------------------------------------------------------------------
    // Entry write value: merge into the tail or build a new masked entry
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_entry       = '0;
        wr_entry.waddr = st_addr[15:1];
        wr_entry.be    = coalesce ? (tail_entry.be | st_mem_byte_enable)
                                  : st_mem_byte_enable;
        for (int b = 0; b < 2; b++) begin
            if (st_mem_byte_enable[b])
                wr_entry.data[8*b +: 8] = st_data[8*b +: 8];
            else if (coalesce)
                wr_entry.data[8*b +: 8] = tail_entry.data[8*b +: 8];
            else
                wr_entry.data[8*b +: 8] = 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Load hazard: any live entry holding the load's word
    // ------------------------------------------------------------------
    always_comb begin
        ld_hazard = 1'b0;
        rel       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Distance from head, modulo DEPTH; live when it is below count.
            rel = PTR_W'(i) - head;
            if (({1'b0, rel} < count) && (entries[i].waddr == ld_addr[15:1]))
                ld_hazard = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of block order.
            if (pop)
                head <= head + 1'b1;
            if (alloc)
                tail <= tail + 1'b1;
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the entry array is cleared on reset so drn_selbyte and
            // drn_wdata read as zero while empty after reset; this keeps the
            // storage in flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else if (push) begin
            entries[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer -- self-checking bench for store_buffer (DEPTH = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well
// before the next rising edge. A queue-based model tracks the expected
// contents in acceptance order.
module tb_store_buffer;
    import lc3b_types::*;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             st_valid;
    logic             st_ready;
    lc3b_word         st_addr;
    lc3b_word         st_data;
    logic [1:0]       st_mem_byte_enable;
    logic             drn_valid;
    logic             drn_ready;
    logic [11:0]      drn_line_addr;
    lc3b_cache_offset drn_offset;
    logic [1:0]       drn_selbyte;
    lc3b_word         drn_wdata;
    lc3b_word         ld_addr;
    logic             ld_hazard;
    logic             empty;
    logic             full;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .st_valid           (st_valid),
        .st_ready           (st_ready),
        .st_addr            (st_addr),
        .st_data            (st_data),
        .st_mem_byte_enable (st_mem_byte_enable),
        .drn_valid          (drn_valid),
        .drn_ready          (drn_ready),
        .drn_line_addr      (drn_line_addr),
        .drn_offset         (drn_offset),
        .drn_selbyte        (drn_selbyte),
        .drn_wdata          (drn_wdata),
        .ld_addr            (ld_addr),
        .ld_hazard          (ld_hazard),
        .empty              (empty),
        .full               (full)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: pending stores, oldest first
    // ------------------------------------------------------------------
    typedef struct {
        logic [14:0] waddr;
        logic [1:0]  be;
        logic [15:0] data;
    } ment_t;

    ment_t mq[$];

    // Apply the rising edge that just happened to the model, using the
    // inputs that were held across it.
    function automatic void model_commit();
        bit    do_pop;
        bit    acc;
        int    last;
        ment_t e;
        if (!reset_n) begin
            mq.delete();
            return;
        end
        do_pop = (mq.size() != 0) && drn_ready;
        acc    = st_valid && (mq.size() < DEPTH) && (st_mem_byte_enable != 2'b00);
        if (acc) begin
            last = mq.size() - 1;
            if (mq.size() != 0 && mq[last].waddr == st_addr[15:1]
                && !(do_pop && mq.size() == 1)) begin
                for (int b = 0; b < 2; b++)
                    if (st_mem_byte_enable[b])
                        mq[last].data[8*b +: 8] = st_data[8*b +: 8];
                mq[last].be = mq[last].be | st_mem_byte_enable;
            end else begin
                e.waddr = st_addr[15:1];
                e.be    = st_mem_byte_enable;
                e.data  = 16'h0000;
                for (int b = 0; b < 2; b++)
                    if (st_mem_byte_enable[b])
                        e.data[8*b +: 8] = st_data[8*b +: 8];
                mq.push_back(e);
            end
        end
        if (do_pop)
            void'(mq.pop_front());
    endfunction

    function automatic bit model_hazard(input logic [15:0] a);
        foreach (mq[i])
            if (mq[i].waddr == a[15:1])
                return 1'b1;
        return 1'b0;
    endfunction

    // Commit the previous cycle, then present new inputs for this cycle.
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic rdy);
        @(negedge clk);
        model_commit();
        st_valid           = v;
        st_addr            = a;
        st_data            = d;
        st_mem_byte_enable = be;
        drn_ready          = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 16'h0000, 16'h0000, 2'b00, rdy);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_mem_byte_enable = '0;
        drn_ready = 1'b0; ld_addr = 16'h0000;
        #2;
        checks++;
        if ({empty, full, st_ready, drn_valid, drn_selbyte, ld_hazard} !== 7'b1010_000) begin
            failures++;
            $display("FAIL reset_state: got e/f/rdy/v/sel/hz=%b expected 1010000",
                     {empty, full, st_ready, drn_valid, drn_selbyte, ld_hazard});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_byte_store();
        drive(1'b1, 16'h1233, 16'hAB00, 2'b10, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        checks++;
        if ({drn_valid, drn_line_addr, drn_offset, drn_selbyte, drn_wdata}
            !== {1'b1, 12'h123, 3'b001, 2'b10, 16'hAB00}) begin
            failures++;
            $display("FAIL byte_store_drain: got v=%b line=%h off=%b sel=%b wd=%h expected 1 123 001 10 ab00",
                     drn_valid, drn_line_addr, drn_offset, drn_selbyte, drn_wdata);
        end
        idle(1'b0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL byte_store_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_coalesce();
        drive(1'b1, 16'h2000, 16'h0011, 2'b01, 1'b0);
        drive(1'b1, 16'h2001, 16'h2200, 2'b10, 1'b0);
        idle(1'b0);
        checks++;
        if ({drn_valid, drn_selbyte, drn_wdata, drn_line_addr, drn_offset}
            !== {1'b1, 2'b11, 16'h2211, 12'h200, 3'b000}) begin
            failures++;
            $display("FAIL coalesce_entry: got v=%b sel=%b wd=%h line=%h off=%b expected 1 11 2211 200 000",
                     drn_valid, drn_selbyte, drn_wdata, drn_line_addr, drn_offset);
        end
        idle(1'b1);
        idle(1'b0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL coalesce_count1: empty=%b after one pop expected 1", empty);
        end
    endtask

    task automatic test_full_wrap();
        logic [15:0] d [5];
        for (int i = 0; i < 5; i++)
            d[i] = 16'($urandom);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 16'h4000 + 16'(i * 16), d[i], 2'b11, 1'b0);
        drive(1'b1, 16'h4040, d[4], 2'b11, 1'b0);
        checks++;
        if ({full, st_ready} !== 2'b10) begin
            failures++;
            $display("FAIL full_after4: got full/st_ready=%b expected 10", {full, st_ready});
        end
        drive(1'b1, 16'h4040, d[4], 2'b11, 1'b0);
        checks++;
        if ({full, st_ready} !== 2'b10) begin
            failures++;
            $display("FAIL fifth_held: got full/st_ready=%b expected 10", {full, st_ready});
        end
        drive(1'b1, 16'h4040, d[4], 2'b11, 1'b1);
        checks++;
        if ({st_ready, drn_wdata} !== {1'b0, d[0]}) begin
            failures++;
            $display("FAIL pulse_cycle: got st_ready=%b wd=%h expected 0 %h", st_ready, drn_wdata, d[0]);
        end
        drive(1'b1, 16'h4040, d[4], 2'b11, 1'b0);
        checks++;
        if ({st_ready, full} !== 2'b10) begin
            failures++;
            $display("FAIL fifth_accept: got st_ready/full=%b expected 10", {st_ready, full});
        end
        for (int i = 1; i < 5; i++) begin
            idle(1'b1);
            checks++;
            if ({drn_valid, drn_wdata, drn_line_addr} !== {1'b1, d[i], 12'h400 + 12'(i)}) begin
                failures++;
                $display("FAIL wrap_order[%0d]: got v=%b wd=%h line=%h expected 1 %h %h",
                         i, drn_valid, drn_wdata, drn_line_addr, d[i], 12'h400 + 12'(i));
            end
        end
        idle(1'b0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 16'h5000, 16'h00A1, 2'b11, 1'b0);
        drive(1'b1, 16'h5010, 16'h00B2, 2'b11, 1'b0);
        drive(1'b1, 16'h5020, 16'h00C3, 2'b11, 1'b1);
        idle(1'b1);
        checks++;
        if ({drn_valid, drn_wdata} !== {1'b1, 16'h00B2}) begin
            failures++;
            $display("FAIL pushpop_second: got v=%b wd=%h expected 1 00b2", drn_valid, drn_wdata);
        end
        idle(1'b1);
        checks++;
        if ({drn_valid, drn_wdata} !== {1'b1, 16'h00C3}) begin
            failures++;
            $display("FAIL pushpop_third: got v=%b wd=%h expected 1 00c3", drn_valid, drn_wdata);
        end
        idle(1'b0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL pushpop_count2: empty=%b after two pops expected 1", empty);
        end
        // Same word as the only entry while it is popping: must allocate.
        drive(1'b1, 16'h6000, 16'h0044, 2'b01, 1'b0);
        drive(1'b1, 16'h6001, 16'h5500, 2'b10, 1'b1);
        checks++;
        if (drn_wdata !== 16'h0044) begin
            failures++;
            $display("FAIL nocoal_head: got wd=%h expected 0044", drn_wdata);
        end
        idle(1'b1);
        checks++;
        if ({drn_valid, drn_selbyte, drn_wdata} !== {1'b1, 2'b10, 16'h5500}) begin
            failures++;
            $display("FAIL nocoal_new: got v=%b sel=%b wd=%h expected 1 10 5500",
                     drn_valid, drn_selbyte, drn_wdata);
        end
        idle(1'b0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL nocoal_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_hazard();
        drive(1'b1, 16'h3004, 16'h1234, 2'b11, 1'b0);
        idle(1'b0);
        ld_addr = 16'h3005; #1;
        checks++;
        if (ld_hazard !== 1'b1) begin
            failures++;
            $display("FAIL hazard_3005: got %b expected 1", ld_hazard);
        end
        ld_addr = 16'h3006; #1;
        checks++;
        if (ld_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hazard_3006: got %b expected 0", ld_hazard);
        end
        ld_addr = 16'h3005;
        idle(1'b1);
        idle(1'b0);
        checks++;
        if (ld_hazard !== 1'b0) begin
            failures++;
            $display("FAIL hazard_after_drain: got %b expected 0", ld_hazard);
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 16'h8000, 16'h1111, 2'b11, 1'b0);
        drive(1'b1, 16'h8010, 16'h2222, 2'b11, 1'b0);
        drive(1'b1, 16'h8020, 16'h3333, 2'b11, 1'b0);
        idle(1'b1);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({empty, drn_valid} !== 2'b10) begin
            failures++;
            $display("FAIL async_reset: got empty/drn_valid=%b expected 10", {empty, drn_valid});
        end
        idle(1'b0);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            checks++;
            if (drn_valid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle[%0d]: got drn_valid=%b expected 0", i, drn_valid);
            end
        end
        drive(1'b1, 16'h9002, 16'h7788, 2'b11, 1'b0);
        idle(1'b1);
        checks++;
        if ({drn_valid, drn_wdata} !== {1'b1, 16'h7788}) begin
            failures++;
            $display("FAIL post_reset_store: got v=%b wd=%h expected 1 7788", drn_valid, drn_wdata);
        end
        idle(1'b0);
    endtask

    task automatic test_random();
        logic [15:0] exp_drn;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 7), 16'h7000 + 16'($urandom_range(0, 7)),
                  16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4));
            ld_addr = 16'h7000 + 16'($urandom_range(0, 9));
            #1;
            checks++;
            if ({empty, full, st_ready, drn_valid}
                !== {mq.size() == 0, mq.size() == DEPTH, mq.size() < DEPTH, mq.size() != 0}) begin
                failures++;
                $display("FAIL rand_status[%0d]: got e/f/rdy/v=%b model size=%0d",
                         n, {empty, full, st_ready, drn_valid}, mq.size());
            end
            checks++;
            if (ld_hazard !== model_hazard(ld_addr)) begin
                failures++;
                $display("FAIL rand_hazard[%0d]: got %b expected %b for ld_addr %h",
                         n, ld_hazard, model_hazard(ld_addr), ld_addr);
            end
            if (mq.size() != 0) begin
                exp_drn = mq[0].data;
                checks++;
                if ({drn_line_addr, drn_offset, drn_selbyte, drn_wdata}
                    !== {mq[0].waddr, mq[0].be, exp_drn}) begin
                    failures++;
                    $display("FAIL rand_head[%0d]: got line=%h off=%b sel=%b wd=%h expected %h %b %b %h",
                             n, drn_line_addr, drn_offset, drn_selbyte, drn_wdata,
                             mq[0].waddr[14:3], mq[0].waddr[2:0], mq[0].be, exp_drn);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_coalesce();
        test_full_wrap();
        test_push_pop();
        test_hazard();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
